matmul_stream_accel: RTL and testbench
======================================

Name: matmul_stream_accel

Overview:
- Parametrised successor to the fixed 2x2 matmul accelerator: computes C = post(A x B + bias) for signed DIM x DIM matrices, one MAC per cycle.
- Adds valid/ready handshakes on input and output with full backpressure.
- Adds run-time bias/ReLU enables, rounding right-shift requantisation to OUT_W, and a sticky saturation flag.
- Sits between the operand buffer and the activation writeback path.

Parameters:
- DIM, 2, matrix dimension (>=1)
- IN_W, 8, signed element width of A and B
- ACC_W, 32, signed accumulator and bias width (>= 2*IN_W + clog2(DIM))
- OUT_W, 16, signed output element width (<= ACC_W)
- SATURATE, 1, 1 = clamp to OUT_W range; 0 = truncate to OUT_W LSBs
- SHIFT_W, 5, width of the shift-amount field

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept operands
- a_mat  in  DIM*DIM*IN_W  row-major; element (i,k) at index i*DIM+k, LSB first
- b_mat  in  DIM*DIM*IN_W  row-major, same packing
- bias_mat  in  DIM*DIM*ACC_W  row-major bias
- bias_en  in  1  add bias; sampled at the input handshake
- relu_en  in  1  apply ReLU; sampled at the input handshake
- shift  in  SHIFT_W  requant right shift; sampled at the input handshake
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- c_mat  out  DIM*DIM*OUT_W  row-major result
- sat_flag  out  1  any element clamped in the current result
- cycle_count  out  16  COMPUTE cycles of the last job
- job_count  out  16  completed output handshakes; wraps modulo 2^16

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; in_ready=1; out_valid=0; c_mat=0; sat_flag=0; cycle_count=0; job_count=0; accumulators 0.
  - Reset mid-job aborts the job with no output.
- Input capture:
  - On in_valid&&in_ready, latch a_mat, b_mat, bias_mat, bias_en, relu_en and shift.
  - Inputs may change freely afterwards.
- FSM:
  - IDLE (in_ready=1): handshake -> COMPUTE; index (i,j,k)=0; cycle_count cleared.
  - COMPUTE (in_ready=0):
    - Each cycle: acc[i][j] += A[i][k]*B[k][j]; cycle_count++.
    - Index order: k fastest, then j, then i.
    - acc[i][j] is zeroed at its k=0 cycle.
    - After DIM^3 cycles -> POST.
  - POST (1 cycle): every element is post-processed in parallel and registered into c_mat and sat_flag. out_valid=1 from the next cycle; -> DONE.
  - DONE: c_mat and out_valid held stable until out_ready. On the handshake: out_valid=0, job_count++, -> IDLE.
- in_ready is 1 only in IDLE.
  - No overlap between jobs.
  - in_valid is ignored outside IDLE.
- Latency:
  - Input handshake at edge E0; out_valid=1 after edge E0+DIM^3+1.
  - DIM=2: out_valid visible 9 cycles after the handshake; cycle_count=8.
- Arithmetic:
  - Products are signed 2*IN_W bits, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W.
  - s = acc + (bias_en ? bias : 0), computed at ACC_W+1 bits with no wrap.
  - If relu_en and s<0: s=0.
  - If shift>0: s = (s + 2^(shift-1)) >>> shift (round half up, arithmetic shift). shift=0: unchanged.
  - SATURATE=1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat_flag=1 if any element is clamped.
  - SATURATE=0: take the OUT_W LSBs; sat_flag stays 0.
- Simultaneous events: in_valid asserted while in DONE is ignored even in the out_ready cycle. It is accepted at the earliest on the cycle after the return to IDLE.

Decomposition:
- Package matmul_pkg:
  - FSM state enum (IDLE, COMPUTE, POST, DONE).
  - Helper functions for clog2 and element index computation.
  - Packing helper constants.
- Sub-module matmul_postproc: combinational single-element bias/ReLU/shift/saturate. Instantiated DIM*DIM times in a generate loop. Outputs element value plus clamped bit.

Test Plan:
- Baseline, DIM=2, bias_en=0, relu_en=0, shift=0, A=[1,2;3,4], B=[5,6;7,8] -> c_mat=[19,22,43,50]; cycle_count=8; out_valid 9 cycles after the handshake; sat_flag=0; job_count=1.
- ReLU, relu_en=1, A=[1,-2;3,-4], B=[2,1;1,2] -> [0,0,2,0]. Same stimulus with relu_en=0 -> [0,-3,2,-5].
- Bias plus rounding shift, A=I, B=[1,2;3,4], bias=[10,20,30,40], bias_en=1, shift=1 -> [6,11,17,22].
- Saturation:
  - All A and B elements 127, bias_en=1, bias=1000 each -> every element 32767, sat_flag=1.
  - A all -128, B all 127, bias -1000 -> every element -32768, sat_flag=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> c_mat stable, in_ready=0, a concurrent in_valid is not accepted.
  - Then assert out_ready -> IDLE the next cycle; job_count increments once.
- Reset mid-job: assert rst in cycle 4 of COMPUTE -> out_valid=0, in_ready=1, cycle_count=0 immediately. A following baseline job yields [19,22,43,50].

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and index helpers for the streaming matrix-multiply accelerator.
package matmul_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, POST, DONE} state_t;

  localparam int CNT_W = 16;

  // Bit width needed to index n items, never below 1 so DIM=1 still gets a counter.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int p = 1; p < n; p = p * 2) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Row-major flat element index.
  function automatic int elem_idx(input int row, input int col, input int dim);
    return row * dim + col;
  endfunction

endpackage

// File: rtl/matmul_postproc.sv
// Single-element post-processing: optional bias, ReLU, rounding right shift,
// then clamp (or truncate) to OUT_W with a clamped indicator.
module matmul_postproc #(
  parameter int ACC_W    = 32,
  parameter int OUT_W    = 16,
  parameter int SATURATE = 1,
  parameter int SHIFT_W  = 5
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [ACC_W-1:0]   bias,
  input  logic               bias_en,
  input  logic               relu_en,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   value,
  output logic               clamped
);
  // Two guard bits: one for the bias sum, one for the rounding increment.
  localparam int EW = ACC_W + 2;
  localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EW-1:0] acc_ext, bias_ext, s_sum, s_relu, s_rnd, s_shift;

  always_comb begin
    acc_ext  = EW'($signed(acc));
    bias_ext = bias_en ? EW'($signed(bias)) : EW'(0);
    s_sum    = acc_ext + bias_ext;
    s_relu   = (relu_en && s_sum[EW-1]) ? EW'(0) : s_sum;
    s_rnd    = (shift == '0) ? EW'(0) : (EW'(1) << (shift - 1'b1));
    s_shift  = (s_relu + s_rnd) >>> shift;
    value    = s_shift[OUT_W-1:0];
    clamped  = 1'b0;
    if (SATURATE != 0) begin
      if (s_shift > MAXV) begin
        value   = MAXV[OUT_W-1:0];
        clamped = 1'b1;
      end else if (s_shift < MINV) begin
        value   = MINV[OUT_W-1:0];
        clamped = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matmul_stream_accel.sv
// Streaming DIM x DIM signed matmul, one MAC per cycle, with valid/ready on both
// sides and a parallel post-processing stage feeding a held result register.
module matmul_stream_accel
  import matmul_pkg::*;
#(
  parameter int DIM      = 2,
  parameter int IN_W     = 8,
  parameter int ACC_W    = 32,
  parameter int OUT_W    = 16,
  parameter int SATURATE = 1,
  parameter int SHIFT_W  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DIM*DIM*IN_W-1:0]    a_mat,
  input  logic [DIM*DIM*IN_W-1:0]    b_mat,
  input  logic [DIM*DIM*ACC_W-1:0]   bias_mat,
  input  logic                       bias_en,
  input  logic                       relu_en,
  input  logic [SHIFT_W-1:0]         shift,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIM*DIM*OUT_W-1:0]   c_mat,
  output logic                       sat_flag,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [CNT_W-1:0]           job_count
);
  localparam int NE    = DIM * DIM;
  localparam int IDX_W = clog2_min1(DIM);
  localparam int NE_W  = clog2_min1(NE);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

  state_t state, next_state;

  logic [NE-1:0][IN_W-1:0]  a_q, b_q;
  logic [NE-1:0][ACC_W-1:0] bias_q, acc;
  logic                     bias_en_q, relu_en_q;
  logic [SHIFT_W-1:0]       shift_q;
  logic [IDX_W-1:0]         i_idx, j_idx, k_idx;
  logic [NE_W-1:0]          a_sel, b_sel, c_sel;
  logic signed [2*IN_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [NE-1:0][OUT_W-1:0] pp_value;
  logic [NE-1:0]            pp_clamped;
  logic                     accept, last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_step = (i_idx == LAST) && (j_idx == LAST) && (k_idx == LAST);

  assign a_sel    = NE_W'(elem_idx(int'(i_idx), int'(k_idx), DIM));
  assign b_sel    = NE_W'(elem_idx(int'(k_idx), int'(j_idx), DIM));
  assign c_sel    = NE_W'(elem_idx(int'(i_idx), int'(j_idx), DIM));
  assign prod     = $signed(a_q[a_sel]) * $signed(b_q[b_sel]);
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = COMPUTE;
      COMPUTE: if (last_step) next_state = POST;
      POST:    next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      bias_q      <= '0;
      bias_en_q   <= 1'b0;
      relu_en_q   <= 1'b0;
      shift_q     <= '0;
      acc         <= '0;
      i_idx       <= '0;
      j_idx       <= '0;
      k_idx       <= '0;
      c_mat       <= '0;
      sat_flag    <= 1'b0;
      cycle_count <= '0;
      job_count   <= '0;
    end else begin
      if (accept) begin
        a_q         <= a_mat;
        b_q         <= b_mat;
        bias_q      <= bias_mat;
        bias_en_q   <= bias_en;
        relu_en_q   <= relu_en;
        shift_q     <= shift;
        i_idx       <= '0;
        j_idx       <= '0;
        k_idx       <= '0;
        cycle_count <= '0;
      end
      if (state == COMPUTE) begin
        // k=0 restarts the element so no separate clear pass is needed.
        acc[c_sel]  <= ((k_idx == '0) ? '0 : acc[c_sel]) + prod_ext;
        cycle_count <= cycle_count + 1'b1;
        if (k_idx == LAST) begin
          k_idx <= '0;
          if (j_idx == LAST) begin
            j_idx <= '0;
            i_idx <= i_idx + 1'b1;
          end else begin
            j_idx <= j_idx + 1'b1;
          end
        end else begin
          k_idx <= k_idx + 1'b1;
        end
      end
      if (state == POST) begin
        c_mat    <= pp_value;
        sat_flag <= |pp_clamped;
      end
      if (state == DONE && out_ready) job_count <= job_count + 1'b1;
    end
  end

  for (genvar e = 0; e < NE; e++) begin : g_pp
    matmul_postproc #(
      .ACC_W(ACC_W), .OUT_W(OUT_W), .SATURATE(SATURATE), .SHIFT_W(SHIFT_W)
    ) u_pp (
      .acc(acc[e]), .bias(bias_q[e]), .bias_en(bias_en_q), .relu_en(relu_en_q),
      .shift(shift_q), .value(pp_value[e]), .clamped(pp_clamped[e])
    );
  end

endmodule

// File: tb/tb_matmul_stream_accel.sv
// Directed bench for matmul_stream_accel (DIM=2, default widths) with a plain
// arithmetic reference model and a per-cycle output comparator.
module tb_matmul_stream_accel;
  localparam int DIM = 2, IN_W = 8, ACC_W = 32, OUT_W = 16, SHIFT_W = 5, NE = DIM * DIM;
  typedef int mat_t [NE];

  logic                   clk = 1'b0, rst = 1'b1;
  logic                   in_valid = 1'b0, in_ready;
  logic [NE*IN_W-1:0]     a_mat = '0, b_mat = '0;
  logic [NE*ACC_W-1:0]    bias_mat = '0;
  logic                   bias_en = 1'b0, relu_en = 1'b0;
  logic [SHIFT_W-1:0]     shift = '0;
  logic                   out_valid, out_ready = 1'b1, sat_flag;
  logic [NE*OUT_W-1:0]    c_mat;
  logic [15:0]            cycle_count, job_count;

  int   checks = 0, failures = 0, exp_jobs = 0;
  bit   exp_pending = 1'b0, exp_sat = 1'b0;
  mat_t exp_c;

  always #5 clk = ~clk;

  matmul_stream_accel #(
    .DIM(DIM), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SATURATE(1), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat), .bias_mat(bias_mat), .bias_en(bias_en),
    .relu_en(relu_en), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
    .c_mat(c_mat), .sat_flag(sat_flag), .cycle_count(cycle_count), .job_count(job_count)
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint c_elem(input int e);
    logic signed [OUT_W-1:0] v;
    v = c_mat[e*OUT_W +: OUT_W];
    return longint'(v);
  endfunction

  // Reference: plain integer matmul, 32-bit wrap, bias, ReLU, round-half-up shift, clamp.
  function automatic void model(input mat_t a, input mat_t b, input mat_t bias,
                                input bit ben, input bit ren, input int sh,
                                output mat_t c, output bit sat);
    longint acc, s;
    sat = 1'b0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        acc = 0;
        for (int k = 0; k < DIM; k++) acc += longint'(a[i*DIM+k]) * longint'(b[k*DIM+j]);
        acc = longint'(int'(acc));
        s = acc + (ben ? longint'(bias[i*DIM+j]) : 0);
        if (ren && s < 0) s = 0;
        if (sh > 0) s = (s + (longint'(1) <<< (sh - 1))) >>> sh;
        if (s > 32767)       begin s = 32767;  sat = 1'b1; end
        else if (s < -32768) begin s = -32768; sat = 1'b1; end
        c[i*DIM+j] = int'(s);
      end
  endfunction

  // Every cycle a result is presented it must match the pending model result.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!exp_pending) chk("unexpected_out_valid", 1, 0);
      else begin
        for (int e = 0; e < NE; e++) chk("cmp_c_mat", c_elem(e), exp_c[e]);
        chk("cmp_sat_flag", sat_flag, exp_sat);
        if (out_ready) begin
          exp_pending = 1'b0;
          exp_jobs++;
        end
      end
    end
  end

  task automatic drive_in(input mat_t a, input mat_t b, input mat_t bias);
    for (int e = 0; e < NE; e++) begin
      a_mat[e*IN_W +: IN_W]      = IN_W'(a[e]);
      b_mat[e*IN_W +: IN_W]      = IN_W'(b[e]);
      bias_mat[e*ACC_W +: ACC_W] = ACC_W'(bias[e]);
    end
  endtask

  task automatic wait_accept(input string tag);
    bit seen;
    seen = 1'b0;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = in_ready;
    end
    chk({tag, "_accept_timeout"}, seen, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble inputs to prove they were captured at the handshake.
    a_mat    = 32'($urandom());
    b_mat    = 32'($urandom());
    bias_mat = {$urandom(), $urandom(), $urandom(), $urandom()};
    bias_en  = ~bias_en;
    relu_en  = ~relu_en;
    shift    = SHIFT_W'($urandom());
  endtask

  task automatic run_job(input string tag, input mat_t a, input mat_t b, input mat_t bias,
                         input bit ben, input bit ren, input int sh,
                         input mat_t lit, input bit lit_sat, input int hold);
    mat_t mc;
    bit   ms, seen;
    int   lat;
    model(a, b, bias, ben, ren, sh, mc, ms);
    for (int e = 0; e < NE; e++) chk({tag, "_model"}, mc[e], lit[e]);
    chk({tag, "_model_sat"}, ms, lit_sat);
    exp_c   = mc;
    exp_sat = ms;
    drive_in(a, b, bias);
    bias_en   = ben;
    relu_en   = ren;
    shift     = SHIFT_W'(sh);
    out_ready = (hold == 0);
    wait_accept(tag);
    exp_pending = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = out_valid;
    end
    chk({tag, "_latency"}, lat, 9);
    chk({tag, "_cycle_count"}, cycle_count, 8);
    chk({tag, "_in_ready_busy"}, in_ready, 0);
    for (int e = 0; e < NE; e++) chk({tag, "_c_lit"}, c_elem(e), lit[e]);
    chk({tag, "_sat_lit"}, sat_flag, lit_sat);
    if (hold > 0) begin
      in_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        chk({tag, "_hold_in_ready"}, in_ready, 0);
        chk({tag, "_hold_out_valid"}, out_valid, 1);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_out_valid_drop"}, out_valid, 0);
    chk({tag, "_idle_in_ready"}, in_ready, 1);
    chk({tag, "_job_count"}, job_count, exp_jobs);
    @(posedge clk);
    #1;
    chk({tag, "_no_stale_accept"}, in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    mat_t a_base, b_base, a_relu, b_relu, a_id, b_bs, bias_bs, a_max, a_min, b_max;
    mat_t bias_p, bias_n, zero, lit;
    a_base = '{1, 2, 3, 4};        b_base = '{5, 6, 7, 8};
    a_relu = '{1, -2, 3, -4};      b_relu = '{2, 1, 1, 2};
    a_id   = '{1, 0, 0, 1};        b_bs   = '{1, 2, 3, 4};
    bias_bs = '{10, 20, 30, 40};
    a_max  = '{127, 127, 127, 127}; b_max = '{127, 127, 127, 127};
    a_min  = '{-128, -128, -128, -128};
    bias_p = '{1000, 1000, 1000, 1000};
    bias_n = '{-1000, -1000, -1000, -1000};
    zero   = '{0, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c_mat_zero", (c_mat == '0), 1);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_job_count", job_count, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    lit = '{19, 22, 43, 50};
    run_job("base", a_base, b_base, zero, 0, 0, 0, lit, 0, 0);
    lit = '{0, 0, 2, 0};
    run_job("relu_on", a_relu, b_relu, zero, 0, 1, 0, lit, 0, 0);
    lit = '{0, -3, 2, -5};
    run_job("relu_off", a_relu, b_relu, zero, 0, 0, 0, lit, 0, 0);
    lit = '{0, -1, 1, -1};
    run_job("neg_shift2", a_relu, b_relu, zero, 0, 0, 2, lit, 0, 0);
    lit = '{6, 11, 17, 22};
    run_job("bias_shift", a_id, b_bs, bias_bs, 1, 0, 1, lit, 0, 0);
    lit = '{32767, 32767, 32767, 32767};
    run_job("sat_pos", a_max, b_max, bias_p, 1, 0, 0, lit, 1, 0);
    lit = '{-32768, -32768, -32768, -32768};
    run_job("sat_neg", a_min, b_max, bias_n, 1, 0, 0, lit, 1, 0);
    lit = '{19, 22, 43, 50};
    run_job("backpressure", a_base, b_base, zero, 0, 0, 0, lit, 0, 5);

    // Abort a job partway through COMPUTE; nothing may come out of it.
    drive_in(a_base, b_base, zero);
    bias_en = 1'b0; relu_en = 1'b0; shift = '0;
    wait_accept("abort");
    repeat (4) @(posedge clk);
    #1;
    chk("abort_mid_cycle_count", cycle_count, 4);
    chk("abort_mid_in_ready", in_ready, 0);
    rst = 1'b1;
    exp_pending = 1'b0;
    exp_jobs = 0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_cycle_count", cycle_count, 0);
    chk("abort_job_count", job_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lit = '{19, 22, 43, 50};
    run_job("post_abort", a_base, b_base, zero, 0, 0, 0, lit, 0, 0);
    chk("final_job_count", job_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
